// File: rtl/bb_uart_master_port_if.sv
// rtl/bb_uart_master_port_if.sv - UART byte link and local bus master signals for the bridge master port
interface bb_uart_master_port_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    logic [7:0]        u_rx_data;
    logic              u_rx_valid;
    logic [7:0]        u_tx_data;
    logic              u_tx_start;
    logic              u_tx_busy;
    logic              m_req;
    logic              m_mode;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_done;
    logic [DATA_W-1:0] m_rdata;

    modport master (
        input  u_rx_data, u_rx_valid, u_tx_busy, m_done, m_rdata,
        output u_tx_data, u_tx_start, m_req, m_mode, m_addr, m_wdata
    );

    modport slave (
        output u_rx_data, u_rx_valid, u_tx_busy, m_done, m_rdata,
        input  u_tx_data, u_tx_start, m_req, m_mode, m_addr, m_wdata
    );
endinterface

// File: rtl/bb_uart_master_port.sv
// rtl/bb_uart_master_port.sv - reassembles 3-byte UART request frames into local bus transactions
module bb_uart_master_port #(
    parameter int BB_ADDR_WIDTH  = 13,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                        clk,
    input  logic                        rstn,
    bb_uart_master_port_if.master       bus,
    output logic                        busy,
    output logic                        overrun
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RX_A1   = 3'd1,
        RX_D    = 3'd2,
        BUS     = 3'd3,
        TX      = 3'd4,
        TX_WAIT = 3'd5
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     mode_q, mode_d;
    logic [BB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic                     seen_q, seen_d;
    logic                     ovr_q, ovr_d;
    logic                     tx_start;
    logic                     accepting;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            seen_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            seen_q  <= seen_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        seen_d    = seen_q;
        ovr_d     = ovr_q;
        tx_start  = 1'b0;
        accepting = (state_q == IDLE) || (state_q == RX_A1) || (state_q == RX_D);

        if (bus.u_rx_valid && !accepting) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.u_rx_valid) begin
                    // Truncation keeps only the address-high field; mode and pad fall off the top.
                    mode_d  = bus.u_rx_data[7];
                    addr_d  = BB_ADDR_WIDTH'({bus.u_rx_data, 8'h00});
                    state_d = RX_A1;
                end
            end
            RX_A1: begin
                if (bus.u_rx_valid) begin
                    addr_d[7:0] = bus.u_rx_data;
                    cnt_d       = '0;
                    state_d     = RX_D;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_D: begin
                if (bus.u_rx_valid) begin
                    wdata_d = DATA_WIDTH'(bus.u_rx_data);
                    cnt_d   = '0;
                    state_d = BUS;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BUS: begin
                if (bus.m_done) begin
                    if (mode_q) begin
                        state_d = IDLE;
                    end else begin
                        rdata_d = bus.m_rdata;
                        state_d = TX;
                    end
                end
            end
            TX: begin
                if (!bus.u_tx_busy) begin
                    tx_start = 1'b1;
                    seen_d   = 1'b0;
                    state_d  = TX_WAIT;
                end
            end
            TX_WAIT: begin
                // The reply is only finished once the tx core has gone busy and then idle again.
                if (bus.u_tx_busy) begin
                    seen_d = 1'b1;
                end else if (seen_q) begin
                    seen_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.m_req      = (state_q == BUS);
    assign bus.m_mode     = mode_q;
    assign bus.m_addr     = addr_q;
    assign bus.m_wdata    = wdata_q;
    assign bus.u_tx_data  = 8'(rdata_q);
    assign bus.u_tx_start = tx_start;
    assign busy           = (state_q != IDLE);
    assign overrun        = ovr_q;
endmodule

// File: tb/tb_bb_uart_master_port.sv
// tb/tb_bb_uart_master_port.sv - directed self-checking bench with a frame-level reference model
module tb_bb_uart_master_port;
    localparam int AW = 13;
    localparam int T  = 100;

    logic clk;
    logic rstn;
    logic busy;
    logic overrun;

    bb_uart_master_port_if #(.ADDR_W(AW), .DATA_W(8)) bif ();

    bb_uart_master_port #(
        .BB_ADDR_WIDTH (AW),
        .DATA_WIDTH    (8),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .bus    (bif),
        .busy   (busy),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errs    = 0;
    int cyc     = 0;
    int tx_starts = 0;
    int start_cyc = 0;
    logic [7:0] last_tx = 8'h00;
    int force_cnt = 0;

    typedef struct {
        bit mode;
        int addr;
        int wdata;
    } txn_t;

    txn_t txn_q[$];
    int   reply_q[$];
    int   fr[3];
    int   nb;
    int   last_c;
    bit   in_txn;
    bit   exp_ov;
    int   phase;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        txn_q.delete();
        reply_q.delete();
        nb     = 0;
        last_c = 0;
        in_txn = 0;
        exp_ov = 0;
        phase  = 0;
    endtask

    // Reference model: compares the current cycle, then absorbs this cycle's inputs.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            cyc++;
            if (!rstn) begin
                model_reset();
            end else begin
                chk("overrun", overrun, exp_ov);
                chk("busy", busy, in_txn || (nb > 0 && (cyc - last_c) <= T));
                chk("m_req", bif.m_req, txn_q.size() > 0);
                if (bif.m_req && txn_q.size() > 0) begin
                    chk("m_mode", bif.m_mode, txn_q[0].mode);
                    chk("m_addr", bif.m_addr, txn_q[0].addr);
                    chk("m_wdata", bif.m_wdata, txn_q[0].wdata);
                end
                chk("u_tx_start", bif.u_tx_start, (phase == 1) && !bif.u_tx_busy);
                if (bif.u_tx_start) begin
                    tx_starts++;
                    start_cyc = cyc;
                    last_tx   = bif.u_tx_data;
                    if (reply_q.size() > 0) chk("u_tx_data", bif.u_tx_data, reply_q[0]);
                end

                if (bif.u_rx_valid) begin
                    if (in_txn) begin
                        exp_ov = 1;
                    end else begin
                        if (nb > 0 && (cyc - last_c) > T) nb = 0;
                        fr[nb] = bif.u_rx_data;
                        nb++;
                        last_c = cyc;
                        if (nb == 3) begin
                            txn_q.push_back('{fr[0] >= 128,
                                              (fr[0] % (1 << (AW - 8))) * 256 + fr[1],
                                              fr[2]});
                            in_txn = 1;
                            nb     = 0;
                        end
                    end
                end

                if (bif.m_done && txn_q.size() > 0) begin
                    if (txn_q[0].mode) begin
                        in_txn = 0;
                    end else begin
                        reply_q.push_back(bif.m_rdata);
                        phase = 1;
                    end
                    void'(txn_q.pop_front());
                end else begin
                    case (phase)
                        1: if (!bif.u_tx_busy) begin
                            phase = 2;
                            if (reply_q.size() > 0) void'(reply_q.pop_front());
                        end
                        2: if (bif.u_tx_busy) phase = 3;
                        3: if (!bif.u_tx_busy) begin
                            phase  = 0;
                            in_txn = 0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // UART tx core stand-in: busy for 10 cycles after each start, plus forced busy windows.
    initial begin
        int emu;
        bit pend;
        emu = 0;
        bif.u_tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            pend = bif.u_tx_start;
            @(posedge clk);
            #2;
            if (pend) emu = 10;
            bif.u_tx_busy = (emu > 0) || (force_cnt > 0);
            if (emu > 0) emu--;
            if (force_cnt > 0) force_cnt--;
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(logic [7:0] b);
        bif.u_rx_data  = b;
        bif.u_rx_valid = 1'b1;
        tick(1);
        bif.u_rx_valid = 1'b0;
    endtask

    task automatic send_frame(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2);
        send_byte(b0);
        tick(2);
        send_byte(b1);
        tick(2);
        send_byte(b2);
    endtask

    task automatic wait_req(int bound);
        int k = 0;
        while (!bif.m_req && k < bound) begin
            tick(1);
            k++;
        end
        chk("wait_req", bif.m_req, 1);
    endtask

    task automatic wait_idle(int bound);
        int k = 0;
        while (busy && k < bound) begin
            tick(1);
            k++;
        end
        chk("wait_idle", busy, 0);
    endtask

    task automatic bus_done(logic [7:0] rd);
        bif.m_rdata = rd;
        bif.m_done  = 1'b1;
        tick(1);
        bif.m_done  = 1'b0;
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_m_req"}, bif.m_req, 0);
        chk({tag, "_m_mode"}, bif.m_mode, 0);
        chk({tag, "_m_addr"}, bif.m_addr, 0);
        chk({tag, "_m_wdata"}, bif.m_wdata, 0);
        chk({tag, "_tx_start"}, bif.u_tx_start, 0);
        chk({tag, "_tx_data"}, bif.u_tx_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        int s0;
        int fcyc;
        rstn           = 1'b0;
        bif.u_rx_data  = 8'h00;
        bif.u_rx_valid = 1'b0;
        bif.m_done     = 1'b0;
        bif.m_rdata    = 8'h00;
        tick(3);
        chk_all_zero("reset");
        rstn = 1'b1;
        tick(2);

        // 1: write, no reply, stray m_done in idle ignored
        s0 = tx_starts;
        send_frame(8'h92, 8'h34, 8'hA5);
        wait_req(20);
        chk("t1_mode", bif.m_mode, 1);
        chk("t1_addr", bif.m_addr, 13'h1234);
        chk("t1_wdata", bif.m_wdata, 8'hA5);
        tick(3);
        bus_done(8'h00);
        wait_idle(10);
        bus_done(8'hFF);
        tick(2);
        chk("t1_stray_busy", busy, 0);
        chk("t1_no_reply", tx_starts - s0, 0);

        // 2: read with reply
        s0 = tx_starts;
        send_frame(8'h05, 8'h67, 8'h00);
        wait_req(20);
        chk("t2_mode", bif.m_mode, 0);
        chk("t2_addr", bif.m_addr, 13'h0567);
        bus_done(8'h3C);
        wait_idle(100);
        chk("t2_starts", tx_starts - s0, 1);
        chk("t2_tx_data", last_tx, 8'h3C);

        // 3: timeout discards lone byte
        send_byte(8'h81);
        tick(150);
        send_frame(8'h10, 8'h20, 8'h30);
        wait_req(20);
        chk("t3_mode", bif.m_mode, 0);
        chk("t3_addr", bif.m_addr, 13'h1020);
        bus_done(8'h5A);
        wait_idle(100);
        chk("t3_overrun", overrun, 0);

        // 3b: gap of exactly TIMEOUT_CYCLES between bytes is still accepted
        send_byte(8'h92);
        tick(99);
        send_byte(8'h34);
        tick(2);
        send_byte(8'hA5);
        wait_req(20);
        chk("t3b_addr", bif.m_addr, 13'h1234);
        chk("t3b_wdata", bif.m_wdata, 8'hA5);
        bus_done(8'h00);
        wait_idle(10);

        // 3c: one cycle longer and the partial frame is dropped
        send_byte(8'h93);
        tick(100);
        send_frame(8'h85, 8'h02, 8'h03);
        wait_req(20);
        chk("t3c_mode", bif.m_mode, 1);
        chk("t3c_addr", bif.m_addr, 13'h0502);
        chk("t3c_wdata", bif.m_wdata, 8'h03);
        bus_done(8'h00);
        wait_idle(10);
        chk("t3c_overrun", overrun, 0);

        // 4: overrun during BUS
        send_frame(8'h0A, 8'hBC, 8'h00);
        wait_req(20);
        tick(2);
        send_byte(8'h55);
        tick(2);
        chk("t4_overrun", overrun, 1);
        chk("t4_addr", bif.m_addr, 13'h0ABC);
        bus_done(8'h77);
        wait_idle(100);
        chk("t4_tx_data", last_tx, 8'h77);
        chk("t4_sticky", overrun, 1);

        // 5: tx backpressure
        s0 = tx_starts;
        send_frame(8'h01, 8'h23, 8'h00);
        wait_req(20);
        chk("t5_addr", bif.m_addr, 13'h0123);
        force_cnt = 20;
        fcyc = cyc;
        bus_done(8'hC3);
        wait_idle(200);
        chk("t5_starts", tx_starts - s0, 1);
        chk("t5_tx_data", last_tx, 8'hC3);
        chk("t5_after_busy", (start_cyc - fcyc) >= 20, 1);

        // 6: reset mid-BUS, then a fresh write
        s0 = tx_starts;
        send_frame(8'h9F, 8'hFF, 8'h11);
        wait_req(20);
        chk("t6_addr_pre", bif.m_addr, 13'h1FFF);
        #2;
        rstn = 1'b0;
        #1;
        chk_all_zero("t6_async");
        tick(3);
        rstn = 1'b1;
        tick(2);
        send_frame(8'h80, 8'h01, 8'hEE);
        wait_req(20);
        chk("t6_mode", bif.m_mode, 1);
        chk("t6_addr", bif.m_addr, 13'h0001);
        chk("t6_wdata", bif.m_wdata, 8'hEE);
        bus_done(8'h00);
        wait_idle(10);
        chk("t6_no_reply", tx_starts - s0, 0);
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
